// File: rtl/load_unit.sv
// Load unit: accepts loads from the load queue, forwards or reads the dcache, broadcasts on the load CDB.
// Define LOAD_FWD_EN to complete loads from forwarded store data without a cache read.
package rv32i_types;
    typedef struct packed {
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] addr2;
        logic [3:0]  rmask;
        logic [4:0]  rd;
        logic [5:0]  pd;
        logic [3:0]  rob_entry;
        logic [31:0] pc;
        logic        data_available;
        logic [31:0] load_data;
    } split_lsq_t;

    typedef struct packed {
        logic        regf_we;
        logic [5:0]  pd;
        logic [4:0]  rd;
        logic [3:0]  rob_entry;
        logic [31:0] rd_v;
    } CDB_t;
endpackage

module load_unit
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  split_lsq_t  load_queue_req,
    output logic        load_ack,
    input  logic        flush,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output CDB_t        load_cdb
);
    typedef enum logic [1:0] {IDLE, MEM_WAIT, DRAIN} state_t;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [29:0] waddr;
        logic [1:0]  sh;
        logic [3:0]  rmask;
        logic [4:0]  rd;
        logic [5:0]  pd;
        logic [3:0]  rob_entry;
    } ld_t;

    state_t state_q, state_d;
    ld_t    ld_q, ld_d;
    CDB_t   cdb_q, cdb_d;
    ld_t    ld_in;
    logic [31:0] mem_w;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  extend = {{24{w[7]}}, w[7:0]};
            3'b001:  extend = {{16{w[15]}}, w[15:0]};
            3'b010:  extend = w;
            3'b100:  extend = {24'b0, w[7:0]};
            3'b101:  extend = {16'b0, w[15:0]};
            default: extend = 32'b0;
        endcase
    endfunction

    function automatic CDB_t result(input ld_t l, input logic [31:0] v);
        result           = '0;
        result.regf_we   = 1'b1;
        result.pd        = l.pd;
        result.rd        = l.rd;
        result.rob_entry = l.rob_entry;
        result.rd_v      = v;
    endfunction

    // Only the word address and the byte offset of addr2 matter past capture.
    logic unused_fields;
`ifdef LOAD_FWD_EN
    assign unused_fields = ^{load_queue_req.pc, load_queue_req.addr[1:0],
                             load_queue_req.addr2[31:2]};
`else
    assign unused_fields = ^{load_queue_req.pc, load_queue_req.addr[1:0],
                             load_queue_req.addr2[31:2], load_queue_req.data_available,
                             load_queue_req.load_data};
`endif

    always_comb begin
        state_d    = state_q;
        ld_d       = ld_q;
        cdb_d      = '0;
        load_ack   = 1'b0;
        dmem_addr  = '0;
        dmem_rmask = '0;

        ld_in.funct3    = load_queue_req.funct3;
        ld_in.waddr     = load_queue_req.addr[31:2];
        ld_in.sh        = load_queue_req.addr2[1:0];
        ld_in.rmask     = load_queue_req.rmask;
        ld_in.rd        = load_queue_req.rd;
        ld_in.pd        = load_queue_req.pd;
        ld_in.rob_entry = load_queue_req.rob_entry;

        // Word loads use the raw word; sub-word loads shift the addressed lane down.
        if (ld_q.funct3 == 3'b010) mem_w = dmem_rdata;
        else mem_w = dmem_rdata >> {ld_q.sh, 3'b000};

        unique case (state_q)
            IDLE: begin
                load_ack = load_req && !flush;
                if (load_ack) begin
                    ld_d = ld_in;
`ifdef LOAD_FWD_EN
                    if (load_queue_req.data_available) begin
                        cdb_d = result(ld_in, extend(ld_in.funct3, load_queue_req.load_data));
                    end else begin
                        state_d = MEM_WAIT;
                    end
`else
                    state_d = MEM_WAIT;
`endif
                end
            end
            MEM_WAIT: begin
                dmem_addr  = {ld_q.waddr, 2'b00};
                dmem_rmask = ld_q.rmask;
                if (dmem_resp) begin
                    state_d = IDLE;
                    cdb_d   = result(ld_q, extend(ld_q.funct3, mem_w));
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                dmem_addr  = {ld_q.waddr, 2'b00};
                dmem_rmask = ld_q.rmask;
                if (dmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) cdb_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ld_q    <= '0;
            cdb_q   <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            cdb_q   <= cdb_d;
        end
    end

    assign load_cdb = cdb_q;
endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with a scoreboard of expected CDB broadcasts.
// Forwarding steps adapt to whether LOAD_FWD_EN is defined.
module tb_load_unit;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    split_lsq_t  req;
    logic        load_ack;
    logic        flush;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    CDB_t        load_cdb;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0]  pd;
        logic [4:0]  rd;
        logic [3:0]  rob;
        logic [31:0] v;
    } exp_t;
    exp_t sb[$];

    load_unit dut (
        .clk(clk), .rst(rst), .load_req(load_req), .load_queue_req(req),
        .load_ack(load_ack), .flush(flush), .dmem_addr(dmem_addr),
        .dmem_rmask(dmem_rmask), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .load_cdb(load_cdb)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic split_lsq_t mk(input logic [2:0] f3, input logic [31:0] a2,
                                      input logic [3:0] rm, input logic [5:0] pd,
                                      input logic da, input logic [31:0] ld);
        split_lsq_t r;
        r.funct3         = f3;
        r.addr           = {a2[31:2], 2'b00};
        r.addr2          = a2;
        r.rmask          = rm;
        r.rd             = pd[4:0] + 5'd1;
        r.pd             = pd;
        r.rob_entry      = pd[3:0] ^ 4'h5;
        r.pc             = 32'h8000_0000 + a2;
        r.data_available = da;
        r.load_data      = ld;
        return r;
    endfunction

    task automatic push(input split_lsq_t r, input logic [31:0] v);
        exp_t e;
        e.pd  = r.pd;
        e.rd  = r.rd;
        e.rob = r.rob_entry;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Sample on the falling edge; every broadcast must match the scoreboard head.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (load_cdb.regf_we) begin
            if (sb.size() == 0) begin
                chk("cdb_spurious", 32'(load_cdb.regf_we), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("cdb_pd", 32'(load_cdb.pd), 32'(e.pd));
                chk("cdb_rd", 32'(load_cdb.rd), 32'(e.rd));
                chk("cdb_rob", 32'(load_cdb.rob_entry), 32'(e.rob));
                chk("cdb_rd_v", load_cdb.rd_v, e.v);
            end
        end
    endtask

    task automatic mem_load(input split_lsq_t r, input logic [31:0] rdata,
                            input int k, input logic [31:0] exp);
        next();
        load_req = 1'b1;
        req = r;
        sample();
        chk("mem_ack", 32'(load_ack), 32'd1);
        chk("mem_rmask_t0", 32'(dmem_rmask), 32'd0);
        push(r, exp);
        next();
        load_req = 1'b0;
        for (int i = 1; i < k; i++) begin
            sample();
            chk("mem_addr_hold", dmem_addr, r.addr);
            chk("mem_rmask_hold", 32'(dmem_rmask), 32'(r.rmask));
            chk("mem_no_cdb", 32'(load_cdb.regf_we), 32'd0);
            next();
        end
        dmem_resp = 1'b1;
        dmem_rdata = rdata;
        sample();
        chk("mem_addr_resp", dmem_addr, r.addr);
        chk("mem_rmask_resp", 32'(dmem_rmask), 32'(r.rmask));
        chk("mem_ack_busy", 32'(load_ack), 32'd0);
        next();
        dmem_resp = 1'b0;
        dmem_rdata = 32'h0;
        sample();
        chk("mem_cdb_we", 32'(load_cdb.regf_we), 32'd1);
        chk("mem_rmask_idle", 32'(dmem_rmask), 32'd0);
        next();
        sample();
        chk("mem_cdb_once", 32'(load_cdb.regf_we), 32'd0);
    endtask

    initial begin
        split_lsq_t r;
        rst = 1'b1;
        load_req = 1'b0;
        flush = 1'b0;
        dmem_resp = 1'b0;
        dmem_rdata = '0;
        req = '0;

        repeat (2) begin
            next();
            sample();
            chk("rst_ack", 32'(load_ack), 32'd0);
            chk("rst_rmask", 32'(dmem_rmask), 32'd0);
            chk("rst_addr", dmem_addr, 32'd0);
            chk("rst_cdb", 32'(load_cdb), 32'd0);
        end
        next();
        rst = 1'b0;
        repeat (2) begin
            sample();
            chk("idle_ack", 32'(load_ack), 32'd0);
            chk("idle_rmask", 32'(dmem_rmask), 32'd0);
            chk("idle_we", 32'(load_cdb.regf_we), 32'd0);
            next();
        end

        mem_load(mk(3'b000, 32'h1003, 4'b1000, 6'd12, 1'b0, '0), 32'h80FF_FFFF, 3, 32'hFFFF_FF80);
        mem_load(mk(3'b101, 32'h2002, 4'b1100, 6'd20, 1'b0, '0), 32'hBEEF_1234, 2, 32'h0000_BEEF);
        mem_load(mk(3'b010, 32'h3000, 4'b1111, 6'd33, 1'b0, '0), 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        mem_load(mk(3'b100, 32'h3101, 4'b0010, 6'd34, 1'b0, '0), 32'h1234_5678, 1, 32'h0000_0056);
        mem_load(mk(3'b001, 32'h3202, 4'b1100, 6'd35, 1'b0, '0), 32'h8001_0000, 2, 32'hFFFF_8001);
        mem_load(mk(3'b011, 32'h3300, 4'b1111, 6'd36, 1'b0, '0), 32'hFFFF_FFFF, 1, 32'h0);

        r = mk(3'b001, 32'h4000, 4'b0011, 6'd40, 1'b1, 32'h0000_F00D);
`ifdef LOAD_FWD_EN
        next();
        load_req = 1'b1;
        req = r;
        sample();
        chk("fwd_ack", 32'(load_ack), 32'd1);
        chk("fwd_rmask_t0", 32'(dmem_rmask), 32'd0);
        push(r, 32'hFFFF_F00D);
        next();
        load_req = 1'b0;
        sample();
        chk("fwd_cdb_we", 32'(load_cdb.regf_we), 32'd1);
        chk("fwd_rmask_t1", 32'(dmem_rmask), 32'd0);
        next();
        sample();
        chk("fwd_cdb_once", 32'(load_cdb.regf_we), 32'd0);
`else
        mem_load(r, 32'h0000_F00D, 2, 32'hFFFF_F00D);
`endif

        next();
        load_req = 1'b1;
        req = mk(3'b000, 32'h0040, 4'b0001, 6'd41, 1'b0, '0);
        flush = 1'b1;
        sample();
        chk("flush_idle_ack", 32'(load_ack), 32'd0);
        next();
        load_req = 1'b0;
        flush = 1'b0;
        sample();
        chk("flush_idle_rmask", 32'(dmem_rmask), 32'd0);

        r = mk(3'b010, 32'h5000, 4'b1111, 6'd50, 1'b0, '0);
        next();
        load_req = 1'b1;
        req = r;
        sample();
        chk("drain_ack_t0", 32'(load_ack), 32'd1);
        next();
        flush = 1'b1;
        sample();
        chk("drain_ack_t1", 32'(load_ack), 32'd0);
        chk("drain_rmask_t1", 32'(dmem_rmask), 32'hF);
        next();
        flush = 1'b0;
        for (int i = 2; i < 5; i++) begin
            sample();
            chk("drain_ack", 32'(load_ack), 32'd0);
            chk("drain_addr", dmem_addr, 32'h5000);
            chk("drain_rmask", 32'(dmem_rmask), 32'hF);
            chk("drain_no_cdb", 32'(load_cdb.regf_we), 32'd0);
            next();
            if (i == 3) flush = 1'b1;
            else flush = 1'b0;
        end
        flush = 1'b0;
        dmem_resp = 1'b1;
        dmem_rdata = 32'h1111_1111;
        sample();
        chk("drain_ack_resp", 32'(load_ack), 32'd0);
        chk("drain_rmask_resp", 32'(dmem_rmask), 32'hF);
        next();
        dmem_resp = 1'b0;
        r = mk(3'b010, 32'h6000, 4'b1111, 6'd9, 1'b0, '0);
        req = r;
        sample();
        chk("drain_ack_resume", 32'(load_ack), 32'd1);
        chk("drain_no_cdb_after", 32'(load_cdb.regf_we), 32'd0);
        next();
        load_req = 1'b0;
        sample();
        chk("coinc_addr", dmem_addr, 32'h6000);
        chk("coinc_rmask", 32'(dmem_rmask), 32'hF);
        next();
        dmem_resp = 1'b1;
        flush = 1'b1;
        dmem_rdata = 32'h2222_2222;
        sample();
        chk("coinc_ack", 32'(load_ack), 32'd0);
        next();
        dmem_resp = 1'b0;
        flush = 1'b0;
        sample();
        chk("coinc_no_cdb", 32'(load_cdb.regf_we), 32'd0);
        chk("coinc_idle_rmask", 32'(dmem_rmask), 32'd0);

`ifdef LOAD_FWD_EN
        for (int i = 0; i < 3; i++) begin
            next();
            load_req = 1'b1;
            r = mk(3'b100, 32'h7000, 4'b0001, 6'(5 + i), 1'b1, 32'(8'h11 * (i + 1)));
            req = r;
            sample();
            chk("b2b_ack", 32'(load_ack), 32'd1);
            if (i > 0) chk("b2b_cdb_pd", 32'(load_cdb.pd), 32'(4 + i));
            push(r, 32'(8'h11 * (i + 1)));
        end
        next();
        load_req = 1'b0;
        sample();
        chk("b2b_cdb_pd_last", 32'(load_cdb.pd), 32'd7);
        next();
        sample();
        chk("b2b_cdb_end", 32'(load_cdb.regf_we), 32'd0);
`else
        for (int i = 0; i < 3; i++) begin
            r = mk(3'b100, 32'h7000, 4'b0001, 6'(5 + i), 1'b1, 32'(8'h11 * (i + 1)));
            mem_load(r, 32'(8'h11 * (i + 1)), 1, 32'(8'h11 * (i + 1)));
        end
`endif

        r = mk(3'b010, 32'h8000, 4'b1111, 6'd60, 1'b0, '0);
        next();
        load_req = 1'b1;
        req = r;
        sample();
        chk("rst_mid_ack", 32'(load_ack), 32'd1);
        next();
        load_req = 1'b0;
        rst = 1'b1;
        sample();
        chk("rst_mid_rmask_pre", 32'(dmem_rmask), 32'hF);
        next();
        rst = 1'b0;
        sample();
        chk("rst_mid_rmask", 32'(dmem_rmask), 32'd0);
        chk("rst_mid_we", 32'(load_cdb.regf_we), 32'd0);
        next();
        load_req = 1'b1;
        sample();
        chk("rst_mid_ack_resume", 32'(load_ack), 32'd1);
        next();
        load_req = 1'b0;
        dmem_resp = 1'b1;
        dmem_rdata = 32'h3333_3333;
        push(r, 32'h3333_3333);
        sample();
        next();
        dmem_resp = 1'b0;
        sample();
        chk("rst_mid_cdb", 32'(load_cdb.regf_we), 32'd1);

        next();
        sample();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
